// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: op and FSM encodings.
// Optional 4-bit fast stepping is enabled by defining SHIFT_SEQ_FAST4_EN.
package shift_sequencer_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic {
    OP_SLL = 1'b0,
    OP_SRA = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the execute stage (master) and the shift sequencer (slave).
interface shift_sequencer_if
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
);

  logic               start;
  op_e                op;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               result_valid;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, op, operand, shamt,
    input  busy, result_valid, result
  );

  modport slave (
    input  start, op, operand, shamt,
    output busy, result_valid, result
  );

endinterface

// File: rtl/shift_sequencer_shift_step.sv
// Combinational single shift step: 1 bit, or 4 bits when sel4_i is set.
// SRA replicates the sign bit into every vacated position.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data_i,
  input  op_e              op_i,
  input  logic             sel4_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (sel4_i) begin
      if (op_i == OP_SRA) data_o = {{4{data_i[WIDTH-1]}}, data_i[WIDTH-1:4]};
      else                data_o = {data_i[WIDTH-5:0], 4'b0000};
    end else begin
      if (op_i == OP_SRA) data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      else                data_o = {data_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shifter (SLL/SRA by 0..WIDTH-1): FSM, step counter and data register.
// Define SHIFT_SEQ_FAST4_EN to take 4-bit steps while at least 4 remain.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  shift_sequencer_if.slave   bus
);

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  op_e                op_q,    op_d;

  logic               sel4;
  logic [SHAMT_W-1:0] step_amt;
  logic [WIDTH-1:0]   step_data;

`ifdef SHIFT_SEQ_FAST4_EN
  assign sel4 = (count_q >= SHAMT_W'(4));
`else
  assign sel4 = 1'b0;
`endif

  assign step_amt = sel4 ? SHAMT_W'(4) : SHAMT_W'(1);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .sel4_i (sel4),
    .data_o (step_data)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          data_d  = bus.operand;
          count_d = bus.shamt;
          op_d    = bus.op;
          state_d = (bus.shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d  = step_data;
        count_d = count_q - step_amt;
        // Leave exactly when this step consumes the remaining count, so it never wraps.
        if (count_q == step_amt) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      op_q    <= op_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.result       = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected results, a negedge monitor checks them.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          vcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   blo = 1;
  int   bhi = 0;
  bit   hold_active = 1'b0;
  logic [31:0] hold_val = '0;
  exp_t q[$];

  shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_shift(input logic o, input logic [31:0] d, input int s);
    logic signed [31:0] sd;
    sd = d;
    if (o) return sd >>> s;
    return d << s;
  endfunction

  function automatic int ref_lat(input int s);
`ifdef SHIFT_SEQ_FAST4_EN
    return s / 4 + s % 4 + 1;
`else
    return s + 1;
`endif
  endfunction

  always @(negedge clk) begin
    bit   exp_b;
    exp_t e;
    exp_b = (cyc >= blo) && (cyc <= bhi);
    total++;
    if (bus.busy !== exp_b) begin
      bad++;
      $display("FAIL busy cyc=%0d actual=%b required=%b", cyc, bus.busy, exp_b);
    end
    if (hold_active) begin
      total++;
      if (bus.result !== hold_val) begin
        bad++;
        $display("FAIL result_hold cyc=%0d actual=%h required=%h", cyc, bus.result, hold_val);
      end
    end
    if (bus.result_valid === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid cyc=%0d actual result=%h required no valid", cyc, bus.result);
      end else begin
        e = q.pop_front();
        if (e.vcyc != cyc || bus.result !== e.res) begin
          bad++;
          $display("FAIL result cyc=%0d actual=%h@%0d required=%h@%0d", cyc, bus.result, cyc, e.res, e.vcyc);
        end else begin
          $display("txn ok cyc=%0d result=%h", cyc, bus.result);
        end
        hold_active = 1'b1;
        hold_val    = bus.result;
      end
    end else if (bus.result_valid !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL result_valid_x cyc=%0d actual=%b required=0", cyc, bus.result_valid);
    end else if (q.size() > 0 && q[0].vcyc <= cyc) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_valid cyc=%0d actual=no valid required=%h@%0d", cyc, e.res, e.vcyc);
    end
  end

  task automatic issue(input logic o, input logic [31:0] d, input logic [4:0] s, input bit early);
    int   guard;
    int   e;
    int   lat;
    exp_t x;
    guard = 0;
    @(negedge clk);
    if (early) begin
      while (bus.result_valid !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
    end else begin
      while (bus.busy !== 1'b0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("FAIL issue_timeout cyc=%0d actual busy=%b required idle", cyc, bus.busy);
    end
    bus.start   = 1'b1;
    bus.op      = op_e'(o);
    bus.operand = d;
    bus.shamt   = s;
    if (early) @(posedge clk);
    @(posedge clk);
    #1;
    e           = cyc;
    hold_active = 1'b0;
    bus.start   = 1'b0;
    bus.operand = $urandom;
    bus.shamt   = 5'($urandom);
    bus.op      = op_e'($urandom_range(0, 1));
    lat    = ref_lat(int'(s));
    x.res  = ref_shift(o, d, int'(s));
    x.vcyc = e + lat - 1;
    q.push_back(x);
    blo = e;
    bhi = e + lat - 1;
  endtask

  initial begin
    int guard;
    int rdly;
    bus.start   = 1'b0;
    bus.op      = OP_SLL;
    bus.operand = '0;
    bus.shamt   = '0;
    repeat (2) @(negedge clk);
    total += 3;
    if (bus.busy !== 1'b0)         begin bad++; $display("FAIL reset_busy actual=%b required=0", bus.busy); end
    if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid actual=%b required=0", bus.result_valid); end
    if (bus.result !== 32'h0)      begin bad++; $display("FAIL reset_result actual=%h required=0", bus.result); end
    rst = 1'b0;

    issue(1'b1, 32'h8000_0000, 5'd4, 1'b0);
    issue(1'b0, 32'h0000_0001, 5'd31, 1'b0);
    issue(1'b0, 32'h1234_5678, 5'd0, 1'b0);
    issue(1'b1, 32'h7FFF_FFFF, 5'd31, 1'b0);
    issue(1'b1, 32'hFFFF_FFFF, 5'd17, 1'b1);

    // A start pulse during an in-flight operation must be dropped.
    issue(1'b0, 32'hA5A5_0F0F, 5'd8, 1'b0);
    repeat (2) @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = OP_SRA;
    bus.operand = 32'hDEAD_BEEF;
    bus.shamt   = 5'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    issue(1'b1, 32'h8765_4321, 5'd5, 1'b1);

    // Asynchronous reset while shifting.
    issue(1'b1, 32'hC000_1234, 5'd20, 1'b0);
`ifdef SHIFT_SEQ_FAST4_EN
    rdly = 3;
`else
    rdly = 7;
`endif
    repeat (rdly) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    q.delete();
    hold_active = 1'b0;
    blo = 1;
    bhi = 0;
    total += 3;
    if (bus.busy !== 1'b0)         begin bad++; $display("FAIL abort_busy actual=%b required=0", bus.busy); end
    if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL abort_valid actual=%b required=0", bus.result_valid); end
    if (bus.result !== 32'h0)      begin bad++; $display("FAIL abort_result actual=%h required=0", bus.result); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    issue(1'b0, 32'h0000_00FF, 5'd12, 1'b0);
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), $urandom, 5'($urandom), 1'($urandom_range(0, 1)));
    end

    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual pending=%0d required=0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
